// File: rtl/mux_2x1_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_2x1_arbiter_if
// Bus bundle between two requesters, the 2:1 arbiter and its downstream sink.
//
//   req_0 / data_0 / gnt_0 : requester 0 request, payload and capture pulse
//   req_1 / data_1 / gnt_1 : requester 1 request, payload and capture pulse
//   out_valid / out_ready  : downstream valid/ready handshake
//   out_data               : captured word presented downstream
//   ctrl                   : mux select of the current owner (0 = port 0)
//   busy                   : status copy of out_valid
//
// Modports:
//   master : the environment side (requesters and downstream sink)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mux_2x1_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req_0;
    logic [WIDTH-1:0] data_0;
    logic             gnt_0;
    logic             req_1;
    logic [WIDTH-1:0] data_1;
    logic             gnt_1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             ctrl;
    logic             busy;

    modport master (
        output req_0, data_0, req_1, data_1, out_ready,
        input  gnt_0, gnt_1, out_valid, out_data, ctrl, busy
    );

    modport slave (
        input  req_0, data_0, req_1, data_1, out_ready,
        output gnt_0, gnt_1, out_valid, out_data, ctrl, busy
    );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// ---------------------------------------------------------------------------
// mux_2x1_arbiter
// Round-robin 2:1 arbiter feeding a single registered output slot.
// A word is captured whenever the slot is free (empty, or being accepted
// this cycle) and a request is pending; the matching gnt_x pulses for the
// first cycle the captured word is visible downstream.
//
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : mux_2x1_arbiter_if.slave (requests, grants, output handshake)
// ---------------------------------------------------------------------------
module mux_2x1_arbiter #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    mux_2x1_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_p0;
    logic             ctrl_p0;
    logic             gnt_0_p0;
    logic             gnt_1_p0;
    logic             last_served;

    logic             free;
    logic             any_req;
    logic             sel;

    // Selection: a lone request wins outright; on a tie the port that was
    // not served last wins.
    always_comb begin
        free    = (state == IDLE) || bus.out_ready;
        any_req = bus.req_0 || bus.req_1;
        sel     = 1'b0;
        if (bus.req_0 && bus.req_1) begin
            sel = ~last_served;
        end else begin
            sel = bus.req_1;
        end
    end

    // ---- stage p0: output slot, grant pulses and round-robin pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_p0     <= '0;
            ctrl_p0     <= 1'b0;
            gnt_0_p0    <= 1'b0;
            gnt_1_p0    <= 1'b0;
            last_served <= 1'b1;   // port 0 wins the first tie
        end else begin
            gnt_0_p0 <= 1'b0;
            gnt_1_p0 <= 1'b0;
            if (free) begin
                if (any_req) begin
                    // Capturing on an accept edge replaces the outgoing word
                    // directly, so a steady stream runs with no bubble.
                    state       <= HOLD;
                    data_p0     <= sel ? bus.data_1 : bus.data_0;
                    ctrl_p0     <= sel;
                    last_served <= sel;
                    gnt_0_p0    <= ~sel;
                    gnt_1_p0    <= sel;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == HOLD);
    assign bus.out_data  = data_p0;
    assign bus.ctrl      = ctrl_p0;
    assign bus.gnt_0     = gnt_0_p0;
    assign bus.gnt_1     = gnt_1_p0;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
module tb_mux_2x1_arbiter;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    mux_2x1_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_2x1_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             r0;
        logic [WIDTH-1:0] d0;
        logic             r1;
        logic [WIDTH-1:0] d1;
        logic             rdy;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic             ec;
        logic             eg0;
        logic             eg1;
    } vec_t;

    vec_t vecs[$];

    // Bookkeeping for the always-on checkers
    int   gnt_cnt  = 0;
    int   acc_cnt  = 0;
    int   disc_cnt = 0;
    logic prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic drive(input logic r0, input logic [WIDTH-1:0] d0,
                         input logic r1, input logic [WIDTH-1:0] d1,
                         input logic rdy);
        bus.req_0     = r0;
        bus.data_0    = d0;
        bus.req_1     = r1;
        bus.data_1    = d1;
        bus.out_ready = rdy;
    endtask

    task automatic check_out(input string name, input logic ev,
                             input logic [WIDTH-1:0] ed, input logic ec,
                             input logic eg0, input logic eg1);
        logic [WIDTH+4:0] got;
        logic [WIDTH+4:0] exp;
        got = {bus.out_valid, bus.busy, bus.out_data, bus.ctrl, bus.gnt_0, bus.gnt_1};
        exp = {ev, ev, ed, ec, eg0, eg1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b busy=%b data=%h ctrl=%b gnt0=%b gnt1=%b, expected valid=%b busy=%b data=%h ctrl=%b gnt0=%b gnt1=%b",
                     name, bus.out_valid, bus.busy, bus.out_data, bus.ctrl, bus.gnt_0, bus.gnt_1,
                     ev, ev, ed, ec, eg0, eg1);
        end
    endtask

    // Always-on checkers, sampled late in the cycle (2 time units before the
    // rising edge) so inputs and outputs are both settled for that edge.
    always @(negedge clk) begin
        #3;
        if (rst_n === 1'b1) begin
            if (bus.gnt_0 === 1'b1) gnt_cnt++;
            if (bus.gnt_1 === 1'b1) gnt_cnt++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) acc_cnt++;
            checks++;
            if (bus.gnt_0 === 1'b1 && bus.gnt_1 === 1'b1) begin
                errors++;
                $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b, expected not both 1", bus.gnt_0, bus.gnt_1);
            end
            if (prev_hold) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, expected valid=1 data=%h",
                             bus.out_valid, bus.out_data, prev_data);
                end
            end
            prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            prev_data = bus.out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    always @(negedge rst_n) begin
        if (bus.out_valid === 1'b1) disc_cnt++;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: inputs applied for one edge, outputs expected after it.
        //                r0  d0     r1  d1     rdy  ev  ed     ec  g0  g1
        vecs.push_back('{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0}); // single req 0
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0}); // drain to idle
        vecs.push_back('{1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1}); // tie: port0 served last
        vecs.push_back('{1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1}); // back-to-back from port 1
        for (int k = 0; k < 5; k++)
            vecs.push_back('{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0}); // backpressure
        vecs.push_back('{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0}); // release: port 0
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0}); // idle, values held
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0}); // idle captures despite ready=0
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0});

        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out("reset_state", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_out("reset_blocks_capture", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1, vecs[i].rdy);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                      vecs[i].eg0, vecs[i].eg1);
            #1;
        end

        // Reset in the middle of a held word
        drive(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
        @(negedge clk);
        check_out("capture_aa", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_out("hold_aa", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out("reset_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1);
        @(negedge clk);
        check_out("reset_held", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_out("tie_after_reset", 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_out("tie_rotate", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
        #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_out("final_drain", 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);
        #4;

        checks++;
        if (gnt_cnt != acc_cnt + disc_cnt || gnt_cnt != 11) begin
            errors++;
            $display("FAIL gnt_accounting: gnts=%0d accepts=%0d discards=%0d, expected gnts=11 equal to accepts+discards",
                     gnt_cnt, acc_cnt, disc_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arbiter.md
MUX_2X1_ARBITER -- requirements
Module: mux_2x1_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both request ports and the output.
REQ-002 clk  input  1  single clock for all state; all registers SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_0  input  1  requester 0 has a word pending on data_0.
REQ-005 data_0  input  WIDTH  requester 0 payload; held stable while req_0 is high.
REQ-006 gnt_0  output  1  one-cycle pulse: the requester 0 word has been captured.
REQ-007 req_1  input  1  requester 1 has a word pending on data_1.
REQ-008 data_1  input  WIDTH  requester 1 payload; held stable while req_1 is high.
REQ-009 gnt_1  output  1  one-cycle pulse: the requester 1 word has been captured.
REQ-010 out_valid  output  1  out_data holds a captured word.
REQ-011 out_ready  input  1  the downstream side accepts the word when out_valid and out_ready are both high.
REQ-012 out_data  output  WIDTH  registered captured word.
REQ-013 ctrl  output  1  mux select of the current owner (0 = in_0 path, 1 = in_1 path); registered.
REQ-014 busy  output  1  equals out_valid; provided for status.

Function
REQ-015 States: IDLE (out_valid=0) and HOLD (out_valid=1). There SHALL be no other states.
REQ-016 The arbiter SHALL be "free" in a cycle when it is in IDLE, or when it is in HOLD and out_ready=1.
REQ-017 On a free cycle with at least one request high, the arbiter SHALL do all of the following at the next edge:
- capture the selected data into out_data;
- set ctrl to the selected port index;
- set out_valid=1 (HOLD);
- pulse the matching gnt_x high for exactly that one following cycle.
REQ-018 Selection rule:
- single request: that port wins;
- both requests high: the port not recorded in last_served wins (round-robin);
- last_served SHALL update to the winner on every capture.
REQ-019 On a free cycle with no request high, the arbiter SHALL go to IDLE (out_valid=0). out_data and ctrl SHALL hold their last values.
REQ-020 In HOLD with out_ready=0, out_data, ctrl and out_valid SHALL be held unchanged, and no gnt SHALL be issued.
REQ-021 Latency: request to out_valid is 1 cycle. The gnt_x pulse SHALL coincide with the first out_valid cycle of that word.
REQ-022 Throughput: with out_ready held at 1 and requests pending, one word SHALL be transferred every cycle, with no bubble.
REQ-023 A req_x sampled high during its own gnt_x cycle SHALL be treated as a new request. A requester that has nothing further to send SHALL drop req_x in that cycle.
REQ-024 gnt_0 and gnt_1 SHALL never be high in the same cycle. Each captured word SHALL produce exactly one gnt pulse and exactly one downstream acceptance.
REQ-025 Back-to-back operation: a capture on the same edge as an accepted word SHALL replace that word without out_valid dropping.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold immediately (asynchronous):
- state=IDLE;
- out_valid=0, busy=0;
- gnt_0=0, gnt_1=0;
- out_data=0, ctrl=0;
- last_served=1, so port 0 wins the first tie.
REQ-027 An assertion of reset during HOLD SHALL discard the held word, and no gnt pulse or acceptance for it SHALL follow.
REQ-028 The first capture SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-029 Single request: reset, then req_0=1 with data_0=8'hA5 and out_ready=1 -> next cycle: out_valid=1, out_data=8'hA5, ctrl=0, gnt_0=1 for one cycle.
REQ-030 Tie rotation: req_0=req_1=1 held, data_0=8'h0F, data_1=8'hF0, out_ready=1 -> out_data sequence 8'h0F, 8'hF0, 8'h0F, 8'hF0; gnt pulses alternate; out_valid stays high throughout.
REQ-031 Backpressure: capture 8'h3C from port 1, out_ready=0 for 5 cycles, req_0 high -> out_data=8'h3C, ctrl=1 and no gnt for all 5 cycles. When out_ready=1, the next edge captures the port 0 word with gnt_0 pulsed.
REQ-032 Drain to idle: one word from port 0, accepted, no further requests -> out_valid=0 the next cycle; out_data and ctrl keep their last values.
REQ-033 Reset mid-transfer: in HOLD with out_ready=0, pulse rst_n low -> out_valid=0, out_data=8'h00 and ctrl=0 immediately; after release, req_0=req_1=1 -> port 0 wins first.
REQ-034 Checkers active in all scenarios:
- gnt_0 and gnt_1 are never high together;
- out_data is stable whenever out_valid=1 and out_ready=0;
- the count of gnt pulses equals the count of accepted words plus any words discarded by reset.
